// File: rtl/power_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : power_gate_ctrl_if
// Brief    : Request/status bundle between a power-gating controller and its
//            requester / power-domain logic.
// Revision : 1.0
// ============================================================================
interface power_gate_ctrl_if;
    logic       sleep_req;
    logic       wake_req;
    logic       pwr_ok;
    logic       pwr_en;
    logic       iso_en;
    logic       save;
    logic       restore;
    logic       awake;
    logic       asleep;
    logic [2:0] state;

    modport slave (
        input  sleep_req, wake_req, pwr_ok,
        output pwr_en, iso_en, save, restore, awake, asleep, state
    );

    modport master (
        output sleep_req, wake_req, pwr_ok,
        input  pwr_en, iso_en, save, restore, awake, asleep, state
    );
endinterface
`default_nettype wire

// File: rtl/power_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : power_gate_ctrl
// Brief    : Moore FSM sequencing isolation, retention save/restore and the
//            header switch of a power-gated CMOS domain.
// Revision : 1.0
// ============================================================================
module power_gate_ctrl #(
    parameter int unsigned PWR_DN_CYC = 2,
    parameter int unsigned PWR_UP_CYC = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    power_gate_ctrl_if.slave  pg
);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_ISO     = 3'd1,
        ST_SAVE    = 3'd2,
        ST_PWR_DN  = 3'd3,
        ST_OFF     = 3'd4,
        ST_PWR_UP  = 3'd5,
        ST_RESTORE = 3'd6,
        ST_DEISO   = 3'd7
    } state_t;

    localparam logic [7:0] c_dn_load = 8'(PWR_DN_CYC - 1);
    localparam logic [7:0] c_up_load = 8'(PWR_UP_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ON;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The dwell counter is loaded on the transition into PWR_DN / PWR_UP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ON: begin
                if (pg.sleep_req) w_state_nxt = ST_ISO;
            end
            ST_ISO: begin
                w_state_nxt = ST_SAVE;
            end
            ST_SAVE: begin
                w_state_nxt = ST_PWR_DN;
                w_cnt_nxt   = c_dn_load;
            end
            ST_PWR_DN: begin
                if (r_cnt == 8'd0) w_state_nxt = ST_OFF;
                else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            ST_OFF: begin
                if (pg.wake_req) begin
                    w_state_nxt = ST_PWR_UP;
                    w_cnt_nxt   = c_up_load;
                end
            end
            ST_PWR_UP: begin
                if (r_cnt != 8'd0) w_cnt_nxt   = r_cnt - 8'd1;
                else if (pg.pwr_ok) w_state_nxt = ST_RESTORE;
            end
            ST_RESTORE: begin
                w_state_nxt = ST_DEISO;
            end
            ST_DEISO: begin
                w_state_nxt = ST_ON;
            end
        endcase
    end

    // Outputs decode the registered state only.
    assign pg.pwr_en  = (r_state != ST_PWR_DN) && (r_state != ST_OFF);
    assign pg.iso_en  = (r_state != ST_ON) && (r_state != ST_DEISO);
    assign pg.save    = (r_state == ST_SAVE);
    assign pg.restore = (r_state == ST_RESTORE);
    assign pg.awake   = (r_state == ST_ON);
    assign pg.asleep  = (r_state == ST_OFF);
    assign pg.state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_power_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_gate_ctrl
// Brief    : Self-checking bench: schedule-based reference model plus
//            directed literal checks and randomized request traffic.
// Revision : 1.0
// ============================================================================
module tb_power_gate_ctrl;

    localparam int DN = 2;
    localparam int UP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    power_gate_ctrl_if pg ();

    power_gate_ctrl #(
        .PWR_DN_CYC (DN),
        .PWR_UP_CYC (UP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pg  (pg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the state the domain will occupy on each upcoming edge is
    // scheduled as a list when a sequence starts.
    int   m_state = 0;
    int   m_seq[$];
    bit   m_pend  = 1'b0;
    bit   chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_seq.delete();
            m_pend  = 1'b0;
            chk_en  = 1'b1;
        end else if (m_seq.size() > 0) begin
            m_state = m_seq.pop_front();
        end else if (m_pend) begin
            if (pg.pwr_ok) begin
                m_state = 6;
                m_seq   = '{7, 0};
                m_pend  = 1'b0;
            end
        end else if (m_state == 0 && pg.sleep_req) begin
            m_state = 1;
            m_seq.push_back(2);
            for (int i = 0; i < DN; i++) m_seq.push_back(3);
            m_seq.push_back(4);
        end else if (m_state == 4 && pg.wake_req) begin
            m_state = 5;
            for (int i = 1; i < UP; i++) m_seq.push_back(5);
            m_pend = 1'b1;
        end
    end

    logic [8:0] exp_v, act_v;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = {3'(m_state),
                     (m_state != 3) && (m_state != 4),
                     (m_state != 0) && (m_state != 7),
                     m_state == 2, m_state == 6, m_state == 0, m_state == 4};
            act_v = {pg.state, pg.pwr_en, pg.iso_en, pg.save, pg.restore,
                     pg.awake, pg.asleep};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_outputs t=%0t: got {state,pwr_en,iso_en,save,restore,awake,asleep}=%b expected %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk_bits(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic [2:0] exp);
        @(negedge clk);
        chk_bits(nm, {5'd0, pg.state}, {5'd0, exp});
    endtask

    initial begin
        rst          = 1'b1;
        pg.sleep_req = 1'b0;
        pg.wake_req  = 1'b0;
        pg.pwr_ok    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_bits("reset_state", {5'd0, pg.state}, 8'd0);
        chk_bits("reset_outs", {4'd0, pg.pwr_en, pg.iso_en, pg.save, pg.restore}, 8'b0000_1000);
        repeat (3) step("idle", 3'd0);
        chk_bits("idle_awake", {7'd0, pg.awake}, 8'd1);

        // sleep sequence
        pg.sleep_req = 1'b1;
        step("slp_e1", 3'd1);
        chk_bits("slp_e1_iso", {7'd0, pg.iso_en}, 8'd1);
        pg.sleep_req = 1'b0;
        step("slp_e2", 3'd2);
        chk_bits("slp_e2_save", {7'd0, pg.save}, 8'd1);
        step("slp_e3", 3'd3);
        chk_bits("slp_e3_pwr", {7'd0, pg.pwr_en}, 8'd0);
        step("slp_e4", 3'd3);
        step("slp_e5", 3'd4);
        chk_bits("slp_e5_asleep", {7'd0, pg.asleep}, 8'd1);

        // wake sequence, supply already good
        pg.wake_req = 1'b1;
        step("wk_e1", 3'd5);
        chk_bits("wk_e1_pwr", {7'd0, pg.pwr_en}, 8'd1);
        pg.wake_req = 1'b0;
        for (int e = 2; e <= 4; e++) step("wk_up", 3'd5);
        step("wk_e5", 3'd6);
        chk_bits("wk_e5_restore", {7'd0, pg.restore}, 8'd1);
        step("wk_e6", 3'd7);
        chk_bits("wk_e6_iso", {7'd0, pg.iso_en}, 8'd0);
        step("wk_e7", 3'd0);

        // back to OFF, then wake with late pwr_ok
        pg.sleep_req = 1'b1;
        step("slp2_e1", 3'd1);
        pg.sleep_req = 1'b0;
        step("slp2_e2", 3'd2);
        step("slp2_e3", 3'd3);
        step("slp2_e4", 3'd3);
        step("slp2_e5", 3'd4);
        pg.pwr_ok   = 1'b0;
        pg.wake_req = 1'b1;
        step("late_e1", 3'd5);
        pg.wake_req = 1'b0;
        for (int e = 2; e <= 9; e++) step("late_hold", 3'd5);
        pg.pwr_ok = 1'b1;
        step("late_e10", 3'd6);
        step("late_e11", 3'd7);
        step("late_e12", 3'd0);

        // both requests in ON, wake pulse inside PWR_DN
        pg.sleep_req = 1'b1;
        pg.wake_req  = 1'b1;
        step("both_e1", 3'd1);
        pg.sleep_req = 1'b0;
        pg.wake_req  = 1'b0;
        step("both_e2", 3'd2);
        step("both_e3", 3'd3);
        pg.wake_req = 1'b1;
        step("ign_e4", 3'd3);
        pg.wake_req = 1'b0;
        step("ign_e5", 3'd4);
        step("ign_e6", 3'd4);

        // both requests in OFF: wake wins
        pg.sleep_req = 1'b1;
        pg.wake_req  = 1'b1;
        step("both_off_e1", 3'd5);
        pg.sleep_req = 1'b0;
        pg.wake_req  = 1'b0;
        for (int e = 2; e <= 4; e++) step("both_off_up", 3'd5);
        step("both_off_e5", 3'd6);
        step("both_off_e6", 3'd7);
        step("both_off_e7", 3'd0);

        // reset while in PWR_DN
        pg.sleep_req = 1'b1;
        step("rstm_e1", 3'd1);
        pg.sleep_req = 1'b0;
        step("rstm_e2", 3'd2);
        step("rstm_e3", 3'd3);
        rst = 1'b1;
        step("rstm_e4", 3'd0);
        chk_bits("rstm_outs", {4'd0, pg.pwr_en, pg.iso_en, pg.save, pg.restore}, 8'b0000_1000);
        rst = 1'b0;
        step("rstm_e5", 3'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pg.sleep_req = ($urandom_range(0, 3) == 0);
            pg.wake_req  = ($urandom_range(0, 3) == 0);
            pg.pwr_ok    = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 249) == 0);
            @(negedge clk);
        end
        rst          = 1'b0;
        pg.sleep_req = 1'b0;
        pg.wake_req  = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
